turn_controller: RTL and testbench

Game-flow sequencer that drives the turn, position and match inputs of the win checker in the chicken-chase board design. It accepts a player's card flip and looks up the tile picture in front of the current player's chicken. It compares the two, then issues a one-cycle move strobe carrying turn (T), target position (N) and match (B). It rotates turns, enforces a per-turn no-repeat card rule and a turn timeout, and freezes on the checker's win flag.

---
 rtl/turn_pkg.sv | 29 ++
 rtl/turn_timer.sv | 40 ++++
 rtl/turn_controller.sv | 165 ++++++++++++++++
 tb/tb_turn_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared types, widths and position helper for the chicken-chase turn sequencer.
// Imported by the controller and reusable by other position counters on the board.
package turn_pkg;

    localparam int POS_W    = 5;
    localparam int CARD_W   = 4;
    localparam int PLAYER_W = 2;

    typedef logic [POS_W-1:0]    pos_t;
    typedef logic [CARD_W-1:0]   card_t;
    typedef logic [PLAYER_W-1:0] player_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CARD,
        S_FETCH,
        S_COMPARE,
        S_ISSUE,
        S_SETTLE,
        S_NEXT_TURN,
        S_GAME_OVER
    } state_e;

    // Step one tile forward along the circular track.
    function automatic pos_t next_pos(input pos_t p, input pos_t last_pos);
        return (p == last_pos) ? '0 : pos_t'(p + pos_t'(1));
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter for the per-turn flip deadline.
// clear reloads the full budget; expire flags the last counting cycle.
module turn_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = LOAD;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates keep every flop sampling pre-edge values.
        if (rst) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == '0);

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: accepts card flips, fetches the tile ahead of the current chicken,
// strobes T/N/B to the win checker, rotates players and freezes once a win is seen.
module turn_controller
    import turn_pkg::*;
#(
    parameter int NUM_PLAYERS  = 4,
    parameter int NUM_TILES    = 24,
    parameter int NUM_CARDS    = 12,
    parameter int TURN_TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                card_valid,
    input  logic [CARD_W-1:0]   card_sel,
    input  logic [CARD_W-1:0]   card_pic,
    input  logic [POS_W-1:0]    cur_pos,
    input  logic                W,
    output logic [POS_W-1:0]    tile_addr,
    input  logic [CARD_W-1:0]   tile_pic,
    output logic [PLAYER_W-1:0] T,
    output logic [POS_W-1:0]    N,
    output logic                B,
    output logic                move_valid,
    output logic                reject,
    output logic                game_over
);

    localparam pos_t    LAST_POS    = POS_W'(NUM_TILES - 1);
    localparam card_t   LAST_CARD   = CARD_W'(NUM_CARDS - 1);
    localparam player_t LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
    localparam int      MASK_W      = 1 << CARD_W;

    state_e              state_q, state_d;
    player_t             t_q, t_d;
    pos_t                n_q, n_d;
    logic                b_q, b_d;
    pos_t                addr_q, addr_d;
    logic                reject_q, reject_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    card_t               pic_q, pic_d;

    logic flip_bad;
    logic flip_ok;
    logic timer_clear;
    logic timer_enable;
    logic timer_expire;

    // Mask is sized to the full selector range so out-of-range indices read a safe 0.
    assign flip_bad = card_valid && ((card_sel > LAST_CARD) || mask_q[card_sel]);
    assign flip_ok  = card_valid && !flip_bad;

    assign timer_enable = (state_q == S_WAIT_CARD);
    assign timer_clear  = !timer_enable || flip_ok;

    turn_timer #(
        .TIMEOUT (TURN_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            n_q      <= '0;
            b_q      <= 1'b0;
            addr_q   <= '0;
            reject_q <= 1'b0;
            mask_q   <= '0;
            pic_q    <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            n_q      <= n_d;
            b_q      <= b_d;
            addr_q   <= addr_d;
            reject_q <= reject_d;
            mask_q   <= mask_d;
            pic_q    <= pic_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (start) state_d = S_WAIT_CARD;
            S_WAIT_CARD: begin
                // An accepted flip in the expiry cycle still wins over the timeout.
                if (flip_ok) begin
                    state_d = S_FETCH;
                end else if (timer_expire) begin
                    state_d = S_NEXT_TURN;
                end
            end
            S_FETCH:     state_d = S_COMPARE;
            S_COMPARE:   state_d = S_ISSUE;
            S_ISSUE:     state_d = S_SETTLE;
            S_SETTLE: begin
                if (W) begin
                    state_d = S_GAME_OVER;
                end else if (b_q) begin
                    state_d = S_WAIT_CARD;
                end else begin
                    state_d = S_NEXT_TURN;
                end
            end
            S_NEXT_TURN: state_d = S_WAIT_CARD;
            S_GAME_OVER: state_d = S_GAME_OVER;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        t_d      = t_q;
        n_d      = n_q;
        b_d      = b_q;
        addr_d   = addr_q;
        reject_d = 1'b0;
        mask_d   = mask_q;
        pic_d    = pic_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    t_d    = '0;
                    mask_d = '0;
                end
            end
            S_WAIT_CARD: begin
                if (flip_bad) begin
                    reject_d = 1'b1;
                end else if (flip_ok) begin
                    mask_d[card_sel] = 1'b1;
                    pic_d            = card_pic;
                    addr_d           = next_pos(cur_pos, LAST_POS);
                end
            end
            S_COMPARE: begin
                // ROM data for addr_q arrives this cycle after the FETCH wait.
                b_d = (tile_pic == pic_q);
                n_d = addr_q;
            end
            S_NEXT_TURN: begin
                t_d    = (t_q == LAST_PLAYER) ? '0 : player_t'(t_q + player_t'(1));
                mask_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        move_valid = (state_q == S_ISSUE);
        game_over  = (state_q == S_GAME_OVER);
        reject     = reject_q;
        tile_addr  = addr_q;
        T          = t_q;
        N          = n_q;
        B          = b_q;
    end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: table of flip transactions plus hand-written
// timeout, win-freeze and mid-operation reset sequences against a small tile ROM model.
module tb_turn_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       card_valid;
    logic [3:0] card_sel;
    logic [3:0] card_pic;
    logic [4:0] cur_pos;
    logic       W;
    logic [4:0] tile_addr;
    logic [3:0] tile_pic;
    logic [1:0] T;
    logic [4:0] N;
    logic       B;
    logic       move_valid;
    logic       reject;
    logic       game_over;

    logic [3:0] rom [0:31];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] pos;
        logic [3:0] sel;
        logic [3:0] pic;
        logic [3:0] rom_pic;
        logic       w;
        logic       exp_reject;
        logic [4:0] exp_addr;
        logic       exp_b;
        logic [1:0] exp_t;
        logic [1:0] exp_t_after;
    } vec_t;

    vec_t vecs [12];

    turn_controller #(
        .NUM_PLAYERS  (4),
        .NUM_TILES    (24),
        .NUM_CARDS    (12),
        .TURN_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .card_valid (card_valid),
        .card_sel   (card_sel),
        .card_pic   (card_pic),
        .cur_pos    (cur_pos),
        .W          (W),
        .tile_addr  (tile_addr),
        .tile_pic   (tile_pic),
        .T          (T),
        .N          (N),
        .B          (B),
        .move_valid (move_valid),
        .reject     (reject),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Registered tile ROM, one cycle of latency.
    always @(posedge clk) tile_pic <= rom[tile_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts just after an edge with the DUT in WAIT_CARD; ends just after the edge
    // that re-enters WAIT_CARD (or GAME_OVER / post-reject).
    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        if (!v.exp_reject) rom[v.exp_addr] = v.rom_pic;
        cur_pos    = v.pos;
        card_sel   = v.sel;
        card_pic   = v.pic;
        card_valid = 1'b1;
        step();
        card_valid = 1'b0;
        if (v.exp_reject) begin
            check($sformatf("v%0d reject_pulse", i), reject, 1'b1);
            check($sformatf("v%0d reject_no_move", i), move_valid, 1'b0);
            step();
            check($sformatf("v%0d reject_one_cycle", i), reject, 1'b0);
            check($sformatf("v%0d reject_no_fetch", i), move_valid, 1'b0);
            return;
        end
        check($sformatf("v%0d no_reject", i), reject, 1'b0);
        check($sformatf("v%0d tile_addr", i), tile_addr, v.exp_addr);
        step();
        check($sformatf("v%0d compare_no_move", i), move_valid, 1'b0);
        step();
        check($sformatf("v%0d move_valid", i), move_valid, 1'b1);
        check($sformatf("v%0d T", i), T, v.exp_t);
        check($sformatf("v%0d N", i), N, v.exp_addr);
        check($sformatf("v%0d B", i), B, v.exp_b);
        W = v.w;
        step();
        check($sformatf("v%0d strobe_one_cycle", i), move_valid, 1'b0);
        check($sformatf("v%0d N_hold", i), N, v.exp_addr);
        check($sformatf("v%0d B_hold", i), B, v.exp_b);
        step();
        W = 1'b0;
        if (v.w) begin
            check($sformatf("v%0d game_over", i), game_over, 1'b1);
            check($sformatf("v%0d T_win", i), T, v.exp_t_after);
        end else if (v.exp_b) begin
            check($sformatf("v%0d T_same_player", i), T, v.exp_t_after);
        end else begin
            check($sformatf("v%0d T_before_rotate", i), T, v.exp_t);
            step();
            check($sformatf("v%0d T_rotated", i), T, v.exp_t_after);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              pos    sel    pic    rom    w     rej   addr   b     t     t_after
        vecs[0]  = '{5'd5,  4'd2,  4'd3, 4'd3, 1'b0, 1'b0, 5'd6,  1'b1, 2'd0, 2'd0};
        vecs[1]  = '{5'd23, 4'd4,  4'd5, 4'd5, 1'b0, 1'b0, 5'd0,  1'b1, 2'd0, 2'd0};
        vecs[2]  = '{5'd0,  4'd2,  4'd3, 4'd0, 1'b0, 1'b1, 5'd0,  1'b0, 2'd0, 2'd0};
        vecs[3]  = '{5'd0,  4'd12, 4'd3, 4'd0, 1'b0, 1'b1, 5'd0,  1'b0, 2'd0, 2'd0};
        vecs[4]  = '{5'd10, 4'd3,  4'd1, 4'd9, 1'b0, 1'b0, 5'd11, 1'b0, 2'd0, 2'd1};
        vecs[5]  = '{5'd10, 4'd2,  4'd7, 4'd7, 1'b0, 1'b0, 5'd11, 1'b1, 2'd1, 2'd1};
        vecs[6]  = '{5'd1,  4'd0,  4'd0, 4'd9, 1'b0, 1'b0, 5'd2,  1'b0, 2'd1, 2'd2};
        vecs[7]  = '{5'd2,  4'd0,  4'd0, 4'd9, 1'b0, 1'b0, 5'd3,  1'b0, 2'd2, 2'd3};
        vecs[8]  = '{5'd3,  4'd1,  4'd1, 4'd7, 1'b0, 1'b0, 5'd4,  1'b0, 2'd3, 2'd0};
        vecs[9]  = '{5'd12, 4'd6,  4'd4, 4'd4, 1'b0, 1'b0, 5'd13, 1'b1, 2'd1, 2'd1};
        vecs[10] = '{5'd13, 4'd7,  4'd4, 4'd8, 1'b0, 1'b0, 5'd14, 1'b0, 2'd1, 2'd2};
        vecs[11] = '{5'd20, 4'd8,  4'd9, 4'd9, 1'b1, 1'b0, 5'd21, 1'b1, 2'd2, 2'd2};

        for (int a = 0; a < 32; a++) rom[a] = 4'hF;
        rst        = 1'b1;
        start      = 1'b0;
        card_valid = 1'b0;
        card_sel   = '0;
        card_pic   = '0;
        cur_pos    = '0;
        W          = 1'b0;
        step();
        step();
        check("reset T", T, 2'd0);
        check("reset N", N, 5'd0);
        check("reset B", B, 1'b0);
        check("reset tile_addr", tile_addr, 5'd0);
        check("reset move_valid", move_valid, 1'b0);
        check("reset reject", reject, 1'b0);
        check("reset game_over", game_over, 1'b0);
        rst = 1'b0;

        // A flip while IDLE is dropped without a reject.
        card_valid = 1'b1;
        card_sel   = 4'd1;
        cur_pos    = 5'd9;
        step();
        card_valid = 1'b0;
        check("idle flip no reject", reject, 1'b0);
        check("idle flip no fetch", tile_addr, 5'd0);

        start = 1'b1;
        step();
        start = 1'b0;

        for (int i = 0; i <= 8; i++) apply_vec(i);

        // Timeout: 16 WAIT_CARD cycles without a flip forfeit the turn.
        for (int c = 1; c <= 15; c++) begin
            step();
            check($sformatf("timeout wait%0d no_move", c), move_valid, 1'b0);
        end
        step();
        check("timeout T before rotate", T, 2'd0);
        check("timeout no_move", move_valid, 1'b0);
        step();
        check("timeout T rotated", T, 2'd1);

        // Flip landing in the expiry cycle is accepted and keeps the turn.
        for (int c = 1; c <= 15; c++) step();
        apply_vec(9);
        apply_vec(10);
        apply_vec(11);

        // Frozen after a win: flips, start and W are ignored.
        card_valid = 1'b1;
        card_sel   = 4'd9;
        start      = 1'b1;
        W          = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("frozen%0d game_over", c), game_over, 1'b1);
            check($sformatf("frozen%0d T", c), T, 2'd2);
            check($sformatf("frozen%0d reject", c), reject, 1'b0);
            check($sformatf("frozen%0d move_valid", c), move_valid, 1'b0);
            check($sformatf("frozen%0d tile_addr", c), tile_addr, 5'd21);
        end
        card_valid = 1'b0;
        start      = 1'b0;
        W          = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        check("post-win reset game_over", game_over, 1'b0);
        check("post-win reset T", T, 2'd0);
        check("post-win reset N", N, 5'd0);
        check("post-win reset B", B, 1'b0);
        check("post-win reset tile_addr", tile_addr, 5'd0);

        // Reset while in COMPARE aborts the move.
        start = 1'b1;
        step();
        start      = 1'b0;
        rom[6]     = 4'd3;
        cur_pos    = 5'd5;
        card_sel   = 4'd2;
        card_pic   = 4'd3;
        card_valid = 1'b1;
        step();
        card_valid = 1'b0;
        check("midrst fetch addr", tile_addr, 5'd6);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst move_valid", move_valid, 1'b0);
        check("midrst tile_addr", tile_addr, 5'd0);
        check("midrst N", N, 5'd0);
        check("midrst B", B, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("midrst idle%0d move_valid", c), move_valid, 1'b0);
        end
        start = 1'b1;
        step();
        start      = 1'b0;
        card_valid = 1'b1;
        step();
        card_valid = 1'b0;
        check("midrst card2 accepted", reject, 1'b0);
        check("midrst card2 addr", tile_addr, 5'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
